// File: rtl/hazard_pkg.sv
// Shared types and defaults for the hazard controller.
// Holds the FSM state enum and the down-counter width helper.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LSTALL,
    FLUSH
  } hz_state_t;

  localparam int REG_W_DEF     = 5;
  localparam int LOAD_LAT_DEF  = 1;
  localparam int FLUSH_CYC_DEF = 1;
  localparam int CNT_W_DEF     = 16;

  function automatic int cnt_width(
    input int a,
    input int b
  );
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter used for hazard statistics.
// Holds at all-ones once full; synchronous active-low reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // count events, sticking at the maximum value
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stall, front-end flush, ext freeze.
// Define HAZARD_PERF_EN to build the saturating perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W     = REG_W_DEF,
  parameter int LOAD_LAT  = LOAD_LAT_DEF,
  parameter int FLUSH_CYC = FLUSH_CYC_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             uses_rt_id,
  input  logic             valid_id,
  input  logic             mem_read_ex,
  input  logic [REG_W-1:0] dest_ex,
  input  logic             branch_id,
  input  logic             prediction,
  input  logic             branch_taken,
  input  logic             jr_id,
  input  logic             ext_stall,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             bubble_ex,
  output logic             flush_ifid,
  output logic             redirect,
  output logic             ld_hazard,
  output logic             br_hazard,
  output logic [CNT_W-1:0] ld_stall_cnt,
  output logic [CNT_W-1:0] br_flush_cnt
);

  localparam int CW = cnt_width(LOAD_LAT, FLUSH_CYC);
  localparam logic [CW-1:0] LD_INIT = CW'(LOAD_LAT - 1);
  localparam logic [CW-1:0] FL_INIT = CW'(FLUSH_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  hz_state_t     state;
  hz_state_t     state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  logic rs_hit;
  logic rt_hit;
  logic mispred;
  logic ld_det;
  logic br_det;

  assign rs_hit  = (rs_id == dest_ex);
  assign rt_hit  = uses_rt_id & (rt_id == dest_ex);
  assign mispred = branch_id & (prediction ^ branch_taken);
  assign ld_det  = valid_id & mem_read_ex
                 & (dest_ex != '0) & (rs_hit | rt_hit);
  assign br_det  = valid_id & (mispred | jr_id) & ~ld_det;

  // next state, sequence counter and pipeline controls
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    stall_pc   = 1'b0;
    stall_ifid = 1'b0;
    bubble_ex  = 1'b0;
    flush_ifid = 1'b0;
    redirect   = 1'b0;
    ld_hazard  = 1'b0;
    br_hazard  = 1'b0;
    if (!rst) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (ext_stall) begin
      stall_pc   = 1'b1;
      stall_ifid = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            ld_det: begin
              ld_hazard  = 1'b1;
              stall_pc   = 1'b1;
              stall_ifid = 1'b1;
              bubble_ex  = 1'b1;
              if (LOAD_LAT > 1) begin
                state_nxt = LSTALL;
                cnt_nxt   = LD_INIT;
              end
            end
            br_det: begin
              br_hazard  = 1'b1;
              redirect   = 1'b1;
              flush_ifid = 1'b1;
              if (FLUSH_CYC > 1) begin
                state_nxt = FLUSH;
                cnt_nxt   = FL_INIT;
              end
            end
            default: ;
          endcase
        end
        LSTALL: begin
          stall_pc   = 1'b1;
          stall_ifid = 1'b1;
          bubble_ex  = 1'b1;
          cnt_nxt    = cnt - 1'b1;
          if (cnt == CNT_ONE) state_nxt = IDLE;
        end
        FLUSH: begin
          flush_ifid = 1'b1;
          cnt_nxt    = cnt - 1'b1;
          if (cnt == CNT_ONE) state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // state and sequence counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] ld_q;
  logic [CNT_W-1:0] br_q;

  sat_counter #(
    .W(CNT_W)
  ) u_ld_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (ld_hazard),
    .count(ld_q)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_br_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (br_hazard),
    .count(br_q)
  );

  assign ld_stall_cnt = rst ? ld_q : '0;
  assign br_flush_cnt = rst ? br_q : '0;
`else
  assign ld_stall_cnt = '0;
  assign br_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised and directed bench for hazard_ctrl.
// Two configurations share one stimulus stream.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs_id;
  logic [4:0] rt_id;
  logic       uses_rt_id;
  logic       valid_id;
  logic       mem_read_ex;
  logic [4:0] dest_ex;
  logic       branch_id;
  logic       prediction;
  logic       branch_taken;
  logic       jr_id;
  logic       ext_stall;

  logic a_sp, a_si, a_bx, a_fl, a_rd, a_lh, a_bh;
  logic [1:0] a_lc, a_bc;
  logic b_sp, b_si, b_bx, b_fl, b_rd, b_lh, b_bh;
  logic [15:0] b_lc, b_bc;

  int total = 0;
  int bad   = 0;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  int lat[2]  = '{3, 1};
  int fcy[2]  = '{2, 1};
  int cmax[2] = '{3, 65535};

  int ld_rem[2] = '{0, 0};
  int fl_rem[2] = '{0, 0};
  int lcnt[2]   = '{0, 0};
  int bcnt[2]   = '{0, 0};
  int nld[2], nfl[2], nlc[2], nbc[2];

  logic e_sp[2], e_bx[2], e_fl[2], e_rd[2], e_lh[2], e_bh[2];
  int   e_lc[2], e_bc[2];

  always #5 clk = ~clk;

  hazard_ctrl #(
    .REG_W(5), .LOAD_LAT(3), .FLUSH_CYC(2), .CNT_W(2)
  ) u_a (
    .clk(clk), .rst(rst),
    .rs_id(rs_id), .rt_id(rt_id),
    .uses_rt_id(uses_rt_id), .valid_id(valid_id),
    .mem_read_ex(mem_read_ex), .dest_ex(dest_ex),
    .branch_id(branch_id), .prediction(prediction),
    .branch_taken(branch_taken), .jr_id(jr_id),
    .ext_stall(ext_stall),
    .stall_pc(a_sp), .stall_ifid(a_si),
    .bubble_ex(a_bx), .flush_ifid(a_fl),
    .redirect(a_rd), .ld_hazard(a_lh),
    .br_hazard(a_bh),
    .ld_stall_cnt(a_lc), .br_flush_cnt(a_bc)
  );

  hazard_ctrl #(
    .REG_W(5), .LOAD_LAT(1), .FLUSH_CYC(1), .CNT_W(16)
  ) u_b (
    .clk(clk), .rst(rst),
    .rs_id(rs_id), .rt_id(rt_id),
    .uses_rt_id(uses_rt_id), .valid_id(valid_id),
    .mem_read_ex(mem_read_ex), .dest_ex(dest_ex),
    .branch_id(branch_id), .prediction(prediction),
    .branch_taken(branch_taken), .jr_id(jr_id),
    .ext_stall(ext_stall),
    .stall_pc(b_sp), .stall_ifid(b_si),
    .bubble_ex(b_bx), .flush_ifid(b_fl),
    .redirect(b_rd), .ld_hazard(b_lh),
    .br_hazard(b_bh),
    .ld_stall_cnt(b_lc), .br_flush_cnt(b_bc)
  );

  task automatic chk(input string tag, input int k,
                     input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d t=%0t",
             tag, k, obs, exp, $time);
    end
  endtask

  // Reference: remaining stall/flush cycles as plain integers.
  task automatic eval(input int k);
    bit ld, br;
    e_sp[k] = 0; e_bx[k] = 0; e_fl[k] = 0;
    e_rd[k] = 0; e_lh[k] = 0; e_bh[k] = 0;
    nld[k] = ld_rem[k]; nfl[k] = fl_rem[k];
    nlc[k] = lcnt[k];   nbc[k] = bcnt[k];
    ld = valid_id && mem_read_ex && (dest_ex != 0) &&
         ((rs_id == dest_ex) || (uses_rt_id && rt_id == dest_ex));
    br = valid_id && !ld &&
         ((branch_id && (prediction != branch_taken)) || jr_id);
    e_lc[k] = (PERF && rst) ? lcnt[k] : 0;
    e_bc[k] = (PERF && rst) ? bcnt[k] : 0;
    if (!rst) begin
      nld[k] = 0; nfl[k] = 0; nlc[k] = 0; nbc[k] = 0;
    end else if (ext_stall) begin
      e_sp[k] = 1;
    end else if (ld_rem[k] > 0) begin
      e_sp[k] = 1; e_bx[k] = 1;
      nld[k] = ld_rem[k] - 1;
    end else if (fl_rem[k] > 0) begin
      e_fl[k] = 1;
      nfl[k] = fl_rem[k] - 1;
    end else if (ld) begin
      e_sp[k] = 1; e_bx[k] = 1; e_lh[k] = 1;
      nld[k] = lat[k] - 1;
      if (lcnt[k] < cmax[k]) nlc[k] = lcnt[k] + 1;
    end else if (br) begin
      e_rd[k] = 1; e_fl[k] = 1; e_bh[k] = 1;
      nfl[k] = fcy[k] - 1;
      if (bcnt[k] < cmax[k]) nbc[k] = bcnt[k] + 1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    eval(0);
    eval(1);
    chk("stall_pc",   0, a_sp, e_sp[0]);
    chk("stall_ifid", 0, a_si, e_sp[0]);
    chk("bubble_ex",  0, a_bx, e_bx[0]);
    chk("flush_ifid", 0, a_fl, e_fl[0]);
    chk("redirect",   0, a_rd, e_rd[0]);
    chk("ld_hazard",  0, a_lh, e_lh[0]);
    chk("br_hazard",  0, a_bh, e_bh[0]);
    chk("ld_cnt",     0, a_lc, e_lc[0]);
    chk("br_cnt",     0, a_bc, e_bc[0]);
    chk("stall_pc",   1, b_sp, e_sp[1]);
    chk("stall_ifid", 1, b_si, e_sp[1]);
    chk("bubble_ex",  1, b_bx, e_bx[1]);
    chk("flush_ifid", 1, b_fl, e_fl[1]);
    chk("redirect",   1, b_rd, e_rd[1]);
    chk("ld_hazard",  1, b_lh, e_lh[1]);
    chk("br_hazard",  1, b_bh, e_bh[1]);
    chk("ld_cnt",     1, b_lc, e_lc[1]);
    chk("br_cnt",     1, b_bc, e_bc[1]);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      ld_rem[k] = nld[k]; fl_rem[k] = nfl[k];
      lcnt[k] = nlc[k];   bcnt[k] = nbc[k];
    end
    #1;
  endtask

  task automatic quiet();
    valid_id = 1; mem_read_ex = 0; dest_ex = 0;
    rs_id = 1; rt_id = 2; uses_rt_id = 0;
    branch_id = 0; prediction = 0; branch_taken = 0;
    jr_id = 0; ext_stall = 0;
  endtask

  task automatic load_r8();
    mem_read_ex = 1; dest_ex = 8; rs_id = 8;
  endtask

  initial begin
    rst = 0;
    quiet();
    load_r8();
    step();
    step();
    rst = 1;
    quiet();
    step();
    // load-use on r8
    load_r8();
    step();
    quiet();
    repeat (4) step();
    // load to r0 never stalls
    mem_read_ex = 1; dest_ex = 0; rs_id = 0;
    step();
    quiet();
    // rt path hazard
    mem_read_ex = 1; dest_ex = 5; rt_id = 5; uses_rt_id = 1;
    step();
    quiet();
    repeat (3) step();
    // mispredict, then a correct prediction
    branch_id = 1; prediction = 1; branch_taken = 0;
    step();
    quiet();
    repeat (3) step();
    branch_id = 1; prediction = 1; branch_taken = 1;
    step();
    quiet();
    // load and jr together
    load_r8(); jr_id = 1;
    step();
    mem_read_ex = 0;
    repeat (5) step();
    quiet();
    // freeze in the middle of a load stall
    load_r8();
    step();
    quiet();
    step();
    ext_stall = 1;
    repeat (2) step();
    ext_stall = 0;
    repeat (3) step();
    // reset during a flush
    branch_id = 1; prediction = 0; branch_taken = 1;
    step();
    quiet();
    rst = 0;
    step();
    rst = 1;
    repeat (2) step();
    // saturate the narrow counter
    repeat (5) begin
      load_r8();
      step();
      quiet();
      repeat (3) step();
    end
    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(0, 39) != 0);
      ext_stall    = ($urandom_range(0, 7) == 0);
      valid_id     = ($urandom_range(0, 5) != 0);
      mem_read_ex  = ($urandom_range(0, 2) == 0);
      dest_ex      = 5'($urandom_range(0, 3));
      rs_id        = 5'($urandom_range(0, 3));
      rt_id        = 5'($urandom_range(0, 3));
      uses_rt_id   = 1'($urandom);
      branch_id    = ($urandom_range(0, 2) == 0);
      prediction   = 1'($urandom);
      branch_taken = 1'($urandom);
      jr_id        = ($urandom_range(0, 9) == 0);
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
